// File: rtl/regfile_mp.sv
// Multi-port RV32I integer register file: two bypassed write ports, N read ports,
// pending-write scoreboard and a post-reset clear sequencer for the storage array.
module regfile_mp #(
  parameter int REG_DEPTH   = 32,
  parameter int REG_WIDTH   = 32,
  parameter int RADDR_WIDTH = 5,
  parameter int NUM_RD      = 2,
  parameter int ZERO_REG    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          init_done,
  input  logic                          we0,
  input  logic [RADDR_WIDTH-1:0]        wd0_addr,
  input  logic [REG_WIDTH-1:0]          wd0_value,
  input  logic                          we1,
  input  logic [RADDR_WIDTH-1:0]        wd1_addr,
  input  logic [REG_WIDTH-1:0]          wd1_value,
  input  logic [NUM_RD*RADDR_WIDTH-1:0] rs_addr,
  output logic [NUM_RD*REG_WIDTH-1:0]   rs_value,
  output logic [NUM_RD-1:0]             rs_busy,
  input  logic                          issue_en,
  input  logic [RADDR_WIDTH-1:0]        issue_addr
);

  localparam int IDX_W = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
  localparam logic [RADDR_WIDTH:0]   DEPTH_L = (RADDR_WIDTH+1)'(REG_DEPTH);
  localparam logic [RADDR_WIDTH-1:0] LAST    = RADDR_WIDTH'(REG_DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state_reg;
  logic [RADDR_WIDTH-1:0]  cnt_reg;
  logic [REG_WIDTH-1:0]    mem [REG_DEPTH];
  logic [REG_DEPTH-1:0]    busy_reg;
  logic [REG_DEPTH-1:0]    busy_next;
  logic                    ready;
  logic                    wr0_ok;
  logic                    wr1_ok;
  logic                    iss_ok;

  // An address is live when it maps to real storage and is not the hardwired zero.
  function automatic logic addr_ok(input logic [RADDR_WIDTH-1:0] a);
    return ({1'b0, a} < DEPTH_L) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  function automatic logic [IDX_W-1:0] idx(input logic [RADDR_WIDTH-1:0] a);
    return a[IDX_W-1:0];
  endfunction

  assign ready  = (state_reg == READY);
  assign wr0_ok = ready && we0 && addr_ok(wd0_addr);
  assign wr1_ok = ready && we1 && addr_ok(wd1_addr);
  assign iss_ok = ready && issue_en && addr_ok(issue_addr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= CLEAR;
      cnt_reg   <= '0;
      init_done <= 1'b0;
    end else if (state_reg == CLEAR) begin
      cnt_reg <= cnt_reg + 1'b1;
      if (cnt_reg == LAST) begin
        state_reg <= READY;
        init_done <= 1'b1;
      end
    end
  end

  // Storage has no reset; the clear sequencer zeroes it. Port 1 is written last so it wins.
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem[idx(cnt_reg)] <= '0;
    end else begin
      if (wr0_ok) mem[idx(wd0_addr)] <= wd0_value;
      if (wr1_ok) mem[idx(wd1_addr)] <= wd1_value;
    end
  end

  // Issue is applied after the write-clears so a new producer overrides a retiring one.
  always_comb begin
    busy_next = busy_reg;
    if (wr0_ok) busy_next[idx(wd0_addr)] = 1'b0;
    if (wr1_ok) busy_next[idx(wd1_addr)] = 1'b0;
    if (iss_ok) busy_next[idx(issue_addr)] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_reg <= '0;
    else      busy_reg <= busy_next;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [RADDR_WIDTH-1:0] ra;
      logic                   hit0;
      logic                   hit1;
      logic [REG_WIDTH-1:0]   rv;
      logic                   rb;

      assign ra   = rs_addr[gi*RADDR_WIDTH +: RADDR_WIDTH];
      assign hit0 = we0 && (wd0_addr == ra);
      assign hit1 = we1 && (wd1_addr == ra);

      always_comb begin
        rv = '0;
        rb = 1'b0;
        if (ready && addr_ok(ra)) begin
          if (hit1)      rv = wd1_value;
          else if (hit0) rv = wd0_value;
          else           rv = mem[idx(ra)];
          rb = busy_reg[idx(ra)] && !(hit0 || hit1);
        end
      end

      assign rs_value[gi*REG_WIDTH +: REG_WIDTH] = rv;
      assign rs_busy[gi] = rb;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default build plus a 16-entry, 3-read-port, no-zero-reg build.
module tb_regfile_mp;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Default build
  logic        rst_a;
  logic        init_a;
  logic        we0, we1, iss;
  logic [4:0]  a0, a1, ia;
  logic [31:0] v0, v1;
  logic [9:0]  rs_addr;
  logic [63:0] rs_value;
  logic [1:0]  rs_busy;

  // 16-entry build
  logic        rst_b;
  logic        init_b;
  logic        we0_b, we1_b, iss_b;
  logic [4:0]  a0_b, a1_b, ia_b;
  logic [31:0] v0_b, v1_b;
  logic [14:0] rs_addr_b;
  logic [95:0] rs_value_b;
  logic [2:0]  rs_busy_b;

  int tests = 0;
  int fails = 0;

  regfile_mp u_dut (
    .clk(clk), .rst(rst_a), .init_done(init_a),
    .we0(we0), .wd0_addr(a0), .wd0_value(v0),
    .we1(we1), .wd1_addr(a1), .wd1_value(v1),
    .rs_addr(rs_addr), .rs_value(rs_value), .rs_busy(rs_busy),
    .issue_en(iss), .issue_addr(ia)
  );

  regfile_mp #(.REG_DEPTH(16), .REG_WIDTH(32), .RADDR_WIDTH(5), .NUM_RD(3), .ZERO_REG(0)) u_dut16 (
    .clk(clk), .rst(rst_b), .init_done(init_b),
    .we0(we0_b), .wd0_addr(a0_b), .wd0_value(v0_b),
    .we1(we1_b), .wd1_addr(a1_b), .wd1_value(v1_b),
    .rs_addr(rs_addr_b), .rs_value(rs_value_b), .rs_busy(rs_busy_b),
    .issue_en(iss_b), .issue_addr(ia_b)
  );

  typedef struct {
    logic        we0;
    logic [4:0]  a0;
    logic [31:0] v0;
    logic        we1;
    logic [4:0]  a1;
    logic [31:0] v1;
    logic        iss;
    logic [4:0]  ia;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        b0;
    logic        b1;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic w0, input logic [4:0] ad0, input logic [31:0] d0,
                              input logic w1, input logic [4:0] ad1, input logic [31:0] d1,
                              input logic is, input logic [4:0] isa,
                              input logic [4:0] q0, input logic [4:0] q1,
                              input logic [31:0] x0, input logic [31:0] x1,
                              input logic y0, input logic y1);
    vec_t v;
    v.we0 = w0; v.a0 = ad0; v.v0 = d0; v.we1 = w1; v.a1 = ad1; v.v1 = d1;
    v.iss = is; v.ia = isa; v.r0 = q0; v.r1 = q1; v.e0 = x0; v.e1 = x1; v.b0 = y0; v.b1 = y1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_a();
    we0 = 0; we1 = 0; iss = 0; a0 = 0; a1 = 0; ia = 0; v0 = 0; v1 = 0;
  endtask

  task automatic idle_b();
    we0_b = 0; we1_b = 0; iss_b = 0; a0_b = 0; a1_b = 0; ia_b = 0; v0_b = 0; v1_b = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 0; rst_b = 0;
    idle_a(); idle_b();
    rs_addr = '0; rs_addr_b = '0;

    // Reset-time outputs
    #1;
    chk("rst_init_done", {31'b0, init_a}, 32'd0);
    chk("rst_value", rs_value[31:0], 32'd0);
    chk("rst_busy", {30'b0, rs_busy}, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    rst_a = 1; rst_b = 1;
    for (int e = 1; e <= 32; e++) begin
      next_cycle();
      chk($sformatf("init_a_e%0d", e), {31'b0, init_a}, {31'b0, (e == 32)});
      if (e <= 16) chk($sformatf("init_b_e%0d", e), {31'b0, init_b}, {31'b0, (e == 16)});
    end

    // Table-driven single-cycle transactions: outputs checked before the committing edge
    vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    vecs[2]  = mk(1, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 7, 5, 32'h22, 32'hDEADBEEF, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 7, 32'h22, 32'h22, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 1, 9, 9, 9, 0, 0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 5, 0, 32'hDEADBEEF, 1, 0);
    vecs[8]  = mk(1, 9, 32'h55, 0, 0, 0, 0, 0, 9, 9, 32'h55, 32'h55, 0, 0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 9, 32'h55, 32'h55, 0, 0);
    vecs[10] = mk(0, 0, 0, 1, 9, 32'h66, 1, 9, 9, 7, 32'h66, 32'h22, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 9, 32'h66, 32'h66, 1, 1);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 9, 0, 32'h66, 0, 1);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 32'h66, 0, 1);
    vecs[14] = mk(1, 3, 32'hA, 1, 4, 32'hB, 0, 0, 3, 4, 32'hA, 32'hB, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 3, 32'hB, 32'hA, 0, 0);
    vecs[16] = mk(0, 0, 0, 1, 31, 32'hFFFFFFFF, 0, 0, 31, 3, 32'hFFFFFFFF, 32'hA, 0, 0);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 31, 30, 32'hFFFFFFFF, 0, 0, 0);
    vecs[18] = mk(1, 9, 32'h77, 0, 0, 0, 0, 0, 9, 9, 32'h77, 32'h77, 0, 0);
    vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 9, 32'h77, 32'h77, 0, 0);

    for (int i = 0; i < 20; i++) begin
      we0 = vecs[i].we0; a0 = vecs[i].a0; v0 = vecs[i].v0;
      we1 = vecs[i].we1; a1 = vecs[i].a1; v1 = vecs[i].v1;
      iss = vecs[i].iss; ia = vecs[i].ia;
      rs_addr = {vecs[i].r1, vecs[i].r0};
      @(negedge clk);
      $display("[TB] vec %0d r0=%0d v0=%h b0=%0d r1=%0d v1=%h b1=%0d", i,
               vecs[i].r0, rs_value[31:0], rs_busy[0], vecs[i].r1, rs_value[63:32], rs_busy[1]);
      chk($sformatf("vec%0d_val0", i), rs_value[31:0], vecs[i].e0);
      chk($sformatf("vec%0d_val1", i), rs_value[63:32], vecs[i].e1);
      chk($sformatf("vec%0d_busy0", i), {31'b0, rs_busy[0]}, {31'b0, vecs[i].b0});
      chk($sformatf("vec%0d_busy1", i), {31'b0, rs_busy[1]}, {31'b0, vecs[i].b1});
      next_cycle();
    end
    idle_a();

    // Full reset with nonzero contents and a pending x12
    iss = 1; ia = 12;
    next_cycle();
    iss = 0;
    rs_addr = {5'd12, 5'd5};
    #1;
    chk("pre_rst_busy12", {31'b0, rs_busy[1]}, 32'd1);
    chk("pre_rst_x5", rs_value[31:0], 32'hDEADBEEF);
    rst_a = 0;
    #1;
    chk("rst2_init_done", {31'b0, init_a}, 32'd0);
    chk("rst2_value", rs_value[31:0], 32'd0);
    chk("rst2_busy", {31'b0, rs_busy[1]}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1;
    rs_addr = {5'd12, 5'd31};
    for (int e = 1; e <= 32; e++) begin
      next_cycle();
      chk($sformatf("clr_init_e%0d", e), {31'b0, init_a}, {31'b0, (e == 32)});
      if (e == 5) chk("clr_read_forced0", rs_value[31:0], 32'd0);
    end
    $display("[TB] clear done, sweeping all addresses");
    for (int a = 0; a < 32; a++) begin
      rs_addr = {5'(31 - a), 5'(a)};
      #1;
      chk($sformatf("sweep_x%0d", a), rs_value[31:0], 32'd0);
    end
    rs_addr = {5'd12, 5'd12};
    #1;
    chk("post_clr_busy12", {31'b0, rs_busy[0]}, 32'd0);

    // Reset mid-clear, with writes and issues attempted during CLEAR
    @(posedge clk);
    #1;
    rst_a = 0;
    #1;
    rst_a = 1;
    for (int e = 1; e <= 10; e++) begin
      next_cycle();
      if (e == 3) begin we0 = 1; a0 = 12; v0 = 32'h99; iss = 1; ia = 12; end
      if (e == 4) idle_a();
    end
    rst_a = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1;
    for (int e = 1; e <= 32; e++) begin
      next_cycle();
      if (e == 2) begin we0 = 1; a0 = 12; v0 = 32'h99; iss = 1; ia = 12; end
      if (e == 3) idle_a();
      chk($sformatf("mid_init_e%0d", e), {31'b0, init_a}, {31'b0, (e == 32)});
    end
    rs_addr = {5'd12, 5'd12};
    #1;
    $display("[TB] mid-clear x12 value=%h busy=%0d", rs_value[31:0], rs_busy[0]);
    chk("mid_x12_value", rs_value[31:0], 32'd0);
    chk("mid_x12_busy", {31'b0, rs_busy[0]}, 32'd0);

    // 16-entry build, x0 writable, out-of-range address ignored
    idle_b();
    we0_b = 1; a0_b = 0; v0_b = 32'hA5; rs_addr_b = {5'd0, 5'd0, 5'd0};
    @(negedge clk);
    chk("p16_x0_bypass", rs_value_b[31:0], 32'hA5);
    next_cycle();
    a0_b = 20; v0_b = 32'h1234; rs_addr_b = {5'd0, 5'd20, 5'd0};
    @(negedge clk);
    chk("p16_x0_read", rs_value_b[31:0], 32'hA5);
    chk("p16_x20_bypass", rs_value_b[63:32], 32'd0);
    next_cycle();
    we0_b = 1; a0_b = 1; v0_b = 32'h1; we1_b = 1; a1_b = 15; v1_b = 32'hF00D;
    rs_addr_b = {5'd20, 5'd1, 5'd15};
    @(negedge clk);
    chk("p16_c_p0", rs_value_b[31:0], 32'hF00D);
    chk("p16_c_p1", rs_value_b[63:32], 32'h1);
    chk("p16_c_p2", rs_value_b[95:64], 32'd0);
    next_cycle();
    idle_b();
    iss_b = 1; ia_b = 20;
    rs_addr_b = {5'd0, 5'd15, 5'd1};
    @(negedge clk);
    chk("p16_d_p0", rs_value_b[31:0], 32'h1);
    chk("p16_d_p1", rs_value_b[63:32], 32'hF00D);
    chk("p16_d_p2", rs_value_b[95:64], 32'hA5);
    next_cycle();
    ia_b = 0;
    rs_addr_b = {5'd15, 5'd0, 5'd20};
    @(negedge clk);
    chk("p16_e_x20_val", rs_value_b[31:0], 32'd0);
    chk("p16_e_busy", {29'b0, rs_busy_b}, 32'd0);
    next_cycle();
    idle_b();
    rs_addr_b = {5'd15, 5'd20, 5'd0};
    @(negedge clk);
    $display("[TB] p16 busy=%b values=%h", rs_busy_b, rs_value_b);
    chk("p16_f_busy", {29'b0, rs_busy_b}, 32'd1);
    chk("p16_f_x0", rs_value_b[31:0], 32'hA5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
